// File: rtl/planificador_fases_pkg.sv
// -----------------------------------------------------------------------------
// planificador_fases_pkg
// Shared definitions for the traffic-light phase scheduler.
//   - estado_t    : FSM state encoding (also driven on the 'fase' debug port)
//   - ROJO/AMARILLO/VERDE : one-hot lamp codes for each signal head
//   - PEA_*       : pedestrian head codes (2'b00 is never produced)
//   - DIR_*       : encoding of the sig_dir "next green direction" bit
//   - semaforo_a_leds / peaton_a_leds : state -> lamp decoders
// -----------------------------------------------------------------------------
package planificador_fases_pkg;

  typedef enum logic [3:0] {
    TODOROJO    = 4'd0,
    NS_VERDE    = 4'd1,
    NS_AMARILLO = 4'd2,
    EO_VERDE    = 4'd3,
    EO_AMARILLO = 4'd4,
    CRUCE       = 4'd5,
    PARPADEO    = 4'd6,
    EMERG_NS    = 4'd7,
    EMERG_EO    = 4'd8
  } estado_t;

  localparam logic [2:0] ROJO     = 3'b100;
  localparam logic [2:0] AMARILLO = 3'b010;
  localparam logic [2:0] VERDE    = 3'b001;

  localparam logic [1:0] PEA_CRUCE    = 2'b01;
  localparam logic [1:0] PEA_ALTO     = 2'b10;
  localparam logic [1:0] PEA_PARPADEO = 2'b11;

  localparam logic DIR_NS = 1'b0;
  localparam logic DIR_EO = 1'b1;

  // Lamp pair for one state: the NS heads (0 and 2) and the EO heads (1 and 3)
  // always show the same colour as their partner.
  typedef struct packed {
    logic [2:0] ns;
    logic [2:0] eo;
  } luces_t;

  function automatic luces_t semaforo_a_leds(input estado_t e);
    luces_t l;
    l.ns = ROJO;
    l.eo = ROJO;
    case (e)
      NS_VERDE,
      EMERG_NS:    l.ns = VERDE;
      NS_AMARILLO: l.ns = AMARILLO;
      EO_VERDE,
      EMERG_EO:    l.eo = VERDE;
      EO_AMARILLO: l.eo = AMARILLO;
      default:     ;
    endcase
    return l;
  endfunction

  function automatic logic [1:0] peaton_a_leds(input estado_t e);
    case (e)
      CRUCE:    return PEA_CRUCE;
      PARPADEO: return PEA_PARPADEO;
      default:  return PEA_ALTO;
    endcase
  endfunction

endpackage

// File: rtl/planificador_fases_temporizador.sv
// -----------------------------------------------------------------------------
// temporizador_fase
// 6-bit loadable down-counter that times each FSM phase in ticks.
//   clk    : system clock
//   rst    : synchronous active-low reset, loads VALOR_RESET
//   cargar : load 'valor' (takes priority over counting)
//   valor  : phase duration minus one
//   tick   : one-clk enable; decrements while the count is non-zero
//   expira : tick arriving with the count already at zero
// The count stops at zero instead of wrapping, so a phase that is being held
// (emergency green extension) keeps reporting expiry on every tick.
// -----------------------------------------------------------------------------
module temporizador_fase #(
  parameter logic [5:0] VALOR_RESET = 6'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cargar,
  input  logic [5:0] valor,
  input  logic       tick,
  output logic       expira
);

  logic [5:0] cuenta;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cuenta <= VALOR_RESET;
    end else if (cargar) begin
      cuenta <= valor;
    end else if (tick && (cuenta != 6'd0)) begin
      cuenta <= cuenta - 6'd1;
    end
  end

  assign expira = tick && (cuenta == 6'd0);

endmodule

// File: rtl/planificador_fases.sv
// -----------------------------------------------------------------------------
// planificador_fases
// Phase scheduler for a four-way intersection with a pedestrian crossing and
// emergency preemption.
//   clk              : system clock, all flops on its rising edge
//   rst              : synchronous active-low reset
//   tick             : one-clk pulse per second from the frequency divider
//   boton_peaton     : synchronized pedestrian push-button
//   emerg_ns/emerg_eo: level emergency requests (NS has priority)
//   semaforo0..3     : lamp codes; 0/2 are NS heads, 1/3 are EO heads
//   peatonal         : pedestrian head code
//   fase             : current state encoding, for debug
// Outputs are registered from the next-state value, so lamps change on the
// same edge as the state register.
// -----------------------------------------------------------------------------
module planificador_fases
  import planificador_fases_pkg::*;
#(
  parameter int T_VERDE    = 10,
  parameter int T_AMARILLO = 3,
  parameter int T_TODOROJO = 1,
  parameter int T_CRUCE    = 8,
  parameter int T_PARPADEO = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       boton_peaton,
  input  logic       emerg_ns,
  input  logic       emerg_eo,
  output logic [2:0] semaforo0,
  output logic [2:0] semaforo1,
  output logic [2:0] semaforo2,
  output logic [2:0] semaforo3,
  output logic [1:0] peatonal,
  output logic [3:0] fase
);

  estado_t estado;
  estado_t estado_sig;
  logic    sig_dir;
  logic    sig_dir_sig;
  logic    ped_pend;
  logic    limpiar_ped;
  logic    boton_ant;
  logic    boton_flanco;
  logic    expira;
  logic    cargar;
  logic [5:0] valor_carga;
  luces_t  luces_sig;

  // Counter preload for each timed state; untimed (emergency) states load 0.
  function automatic logic [5:0] duracion(input estado_t e);
    case (e)
      TODOROJO:    return 6'(T_TODOROJO - 1);
      NS_VERDE,
      EO_VERDE:    return 6'(T_VERDE - 1);
      NS_AMARILLO,
      EO_AMARILLO: return 6'(T_AMARILLO - 1);
      CRUCE:       return 6'(T_CRUCE - 1);
      PARPADEO:    return 6'(T_PARPADEO - 1);
      default:     return 6'd0;
    endcase
  endfunction

  assign boton_flanco = boton_peaton && !boton_ant;

  // Every state change enters a state that needs a fresh count; no state ever
  // transitions to itself.
  assign cargar      = (estado_sig != estado);
  assign valor_carga = duracion(estado_sig);

  temporizador_fase #(
    .VALOR_RESET(6'(T_TODOROJO - 1))
  ) u_temporizador (
    .clk   (clk),
    .rst   (rst),
    .cargar(cargar),
    .valor (valor_carga),
    .tick  (tick),
    .expira(expira)
  );

  always_comb begin
    estado_sig  = estado;
    sig_dir_sig = sig_dir;
    limpiar_ped = 1'b0;
    case (estado)
      // Clearance expiry picks the next service: emergency beats pedestrian,
      // pedestrian beats the normal green rotation.
      TODOROJO: begin
        if (expira) begin
          if (emerg_ns) begin
            estado_sig  = EMERG_NS;
            sig_dir_sig = DIR_EO;
          end else if (emerg_eo) begin
            estado_sig  = EMERG_EO;
            sig_dir_sig = DIR_NS;
          end else if (ped_pend) begin
            estado_sig  = CRUCE;
            limpiar_ped = 1'b1;
          end else if (sig_dir == DIR_NS) begin
            estado_sig  = NS_VERDE;
            sig_dir_sig = DIR_EO;
          end else begin
            estado_sig  = EO_VERDE;
            sig_dir_sig = DIR_NS;
          end
        end
      end
      // A matching emergency holds the green; an opposing one cuts it short
      // on any clk edge. NS wins when both are raised.
      NS_VERDE: begin
        if (!emerg_ns && (emerg_eo || expira)) estado_sig = NS_AMARILLO;
      end
      EO_VERDE: begin
        if (emerg_ns || (!emerg_eo && expira)) estado_sig = EO_AMARILLO;
      end
      NS_AMARILLO,
      EO_AMARILLO,
      PARPADEO: begin
        if (expira) estado_sig = TODOROJO;
      end
      CRUCE: begin
        if (expira) estado_sig = PARPADEO;
      end
      EMERG_NS: begin
        if (!emerg_ns) estado_sig = NS_AMARILLO;
      end
      EMERG_EO: begin
        if (!emerg_eo) estado_sig = EO_AMARILLO;
      end
      default: estado_sig = TODOROJO;
    endcase
  end

  always_comb begin
    luces_sig = semaforo_a_leds(estado_sig);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      estado    <= TODOROJO;
      sig_dir   <= DIR_NS;
      ped_pend  <= 1'b0;
      // Treat the button as already pressed so a press held through reset is
      // not seen as a fresh edge on release.
      boton_ant <= 1'b1;
      semaforo0 <= ROJO;
      semaforo1 <= ROJO;
      semaforo2 <= ROJO;
      semaforo3 <= ROJO;
      peatonal  <= PEA_ALTO;
      fase      <= TODOROJO;
    end else begin
      estado    <= estado_sig;
      sig_dir   <= sig_dir_sig;
      boton_ant <= boton_peaton;
      if (limpiar_ped) begin
        ped_pend <= 1'b0;
      end else if (boton_flanco && (estado != CRUCE) && (estado != PARPADEO)) begin
        ped_pend <= 1'b1;
      end
      semaforo0 <= luces_sig.ns;
      semaforo1 <= luces_sig.eo;
      semaforo2 <= luces_sig.ns;
      semaforo3 <= luces_sig.eo;
      peatonal  <= peaton_a_leds(estado_sig);
      fase      <= estado_sig;
    end
  end

endmodule

// File: tb/tb_planificador_fases.sv
module tb_planificador_fases;
  import planificador_fases_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       boton_peaton;
  logic       emerg_ns;
  logic       emerg_eo;
  logic [2:0] semaforo0, semaforo1, semaforo2, semaforo3;
  logic [1:0] peatonal;
  logic [3:0] fase;

  int checks   = 0;
  int failures = 0;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] A = 3'b010;
  localparam logic [2:0] V = 3'b001;
  localparam logic [1:0] P_ALTO  = 2'b10;
  localparam logic [1:0] P_CRUCE = 2'b01;
  localparam logic [1:0] P_PARP  = 2'b11;

  // {fase, semaforo0, semaforo1, semaforo2, semaforo3, peatonal}
  localparam logic [17:0] E_TR  = {TODOROJO,    R, R, R, R, P_ALTO};
  localparam logic [17:0] E_NSV = {NS_VERDE,    V, R, V, R, P_ALTO};
  localparam logic [17:0] E_NSA = {NS_AMARILLO, A, R, A, R, P_ALTO};
  localparam logic [17:0] E_EOV = {EO_VERDE,    R, V, R, V, P_ALTO};
  localparam logic [17:0] E_EOA = {EO_AMARILLO, R, A, R, A, P_ALTO};
  localparam logic [17:0] E_CRU = {CRUCE,       R, R, R, R, P_CRUCE};
  localparam logic [17:0] E_PAR = {PARPADEO,    R, R, R, R, P_PARP};
  localparam logic [17:0] E_ENS = {EMERG_NS,    V, R, V, R, P_ALTO};
  localparam logic [17:0] E_EEO = {EMERG_EO,    R, V, R, V, P_ALTO};

  logic [17:0] obs;
  assign obs = {fase, semaforo0, semaforo1, semaforo2, semaforo3, peatonal};

  planificador_fases dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .boton_peaton(boton_peaton),
    .emerg_ns    (emerg_ns),
    .emerg_eo    (emerg_eo),
    .semaforo0   (semaforo0),
    .semaforo1   (semaforo1),
    .semaforo2   (semaforo2),
    .semaforo3   (semaforo3),
    .peatonal    (peatonal),
    .fase        (fase)
  );

  always #5 clk = ~clk;

  task automatic reloj(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One tick period: tick high for one clk, then three idle clks.
  task automatic dar_tick();
    tick = 1'b1;
    reloj(1);
    tick = 1'b0;
    reloj(3);
  endtask

  task automatic aplicar_reset();
    rst = 1'b0; tick = 1'b0; boton_peaton = 1'b0; emerg_ns = 1'b0; emerg_eo = 1'b0;
    reloj(2);
    rst = 1'b1;
    reloj(1);
  endtask

  task automatic test_reset();
    rst = 1'b0; tick = 1'b1; boton_peaton = 1'b1; emerg_ns = 1'b1; emerg_eo = 1'b1;
    reloj(3);
    checks++;
    if (obs !== E_TR) begin failures++; $display("FAIL reset_estado: got %h expected %h", obs, E_TR); end
    rst = 1'b1; tick = 1'b0; boton_peaton = 1'b0; emerg_ns = 1'b0; emerg_eo = 1'b0;
    reloj(2);
    checks++;
    if (obs !== E_TR) begin failures++; $display("FAIL post_reset_sin_tick: got %h expected %h", obs, E_TR); end
    dar_tick();
    checks++;
    if (obs !== E_NSV) begin failures++; $display("FAIL reset_ignora_entradas: got %h expected %h", obs, E_NSV); end
  endtask

  task automatic test_ciclo_normal();
    aplicar_reset();
    reloj(5);
    checks++;
    if (obs !== E_TR) begin failures++; $display("FAIL sin_tick_sin_cambio: got %h expected %h", obs, E_TR); end
    tick = 1'b1;
    reloj(1);
    tick = 1'b0;
    checks++;
    if (obs !== E_NSV) begin failures++; $display("FAIL latencia_verde: got %h expected %h", obs, E_NSV); end
    reloj(3);
    for (int i = 0; i < 9; i++) begin
      dar_tick();
      checks++;
      if (obs !== E_NSV) begin failures++; $display("FAIL ns_verde_dur[%0d]: got %h expected %h", i, obs, E_NSV); end
    end
    for (int i = 0; i < 3; i++) begin
      dar_tick();
      checks++;
      if (obs !== E_NSA) begin failures++; $display("FAIL ns_amarillo[%0d]: got %h expected %h", i, obs, E_NSA); end
    end
    dar_tick();
    checks++;
    if (obs !== E_TR) begin failures++; $display("FAIL todorojo: got %h expected %h", obs, E_TR); end
    for (int i = 0; i < 10; i++) begin
      dar_tick();
      checks++;
      if (obs !== E_EOV) begin failures++; $display("FAIL eo_verde[%0d]: got %h expected %h", i, obs, E_EOV); end
    end
    dar_tick();
    checks++;
    if (obs !== E_EOA) begin failures++; $display("FAIL eo_amarillo: got %h expected %h", obs, E_EOA); end
  endtask

  task automatic test_peaton();
    aplicar_reset();
    dar_tick();
    checks++;
    if (obs !== E_NSV) begin failures++; $display("FAIL peaton_inicio: got %h expected %h", obs, E_NSV); end
    // Two presses while pending must still give a single walk phase.
    boton_peaton = 1'b1; reloj(1); boton_peaton = 1'b0; reloj(1);
    boton_peaton = 1'b1; reloj(1); boton_peaton = 1'b0;
    for (int i = 0; i < 9; i++) dar_tick();
    checks++;
    if (obs !== E_NSV) begin failures++; $display("FAIL peaton_ns_verde: got %h expected %h", obs, E_NSV); end
    for (int i = 0; i < 3; i++) begin
      dar_tick();
      checks++;
      if (obs !== E_NSA) begin failures++; $display("FAIL peaton_ns_amarillo[%0d]: got %h expected %h", i, obs, E_NSA); end
    end
    dar_tick();
    checks++;
    if (obs !== E_TR) begin failures++; $display("FAIL peaton_rojo: got %h expected %h", obs, E_TR); end
    dar_tick();
    checks++;
    if (obs !== E_CRU) begin failures++; $display("FAIL cruce_inicio: got %h expected %h", obs, E_CRU); end
    // Press during the walk phase must be ignored.
    boton_peaton = 1'b1; reloj(1); boton_peaton = 1'b0;
    for (int i = 0; i < 7; i++) begin
      dar_tick();
      checks++;
      if (obs !== E_CRU) begin failures++; $display("FAIL cruce_dur[%0d]: got %h expected %h", i, obs, E_CRU); end
    end
    for (int i = 0; i < 4; i++) begin
      dar_tick();
      checks++;
      if (obs !== E_PAR) begin failures++; $display("FAIL parpadeo[%0d]: got %h expected %h", i, obs, E_PAR); end
    end
    dar_tick();
    checks++;
    if (obs !== E_TR) begin failures++; $display("FAIL peaton_rojo_final: got %h expected %h", obs, E_TR); end
    dar_tick();
    checks++;
    if (obs !== E_EOV) begin failures++; $display("FAIL peaton_sigue_eo: got %h expected %h", obs, E_EOV); end
    for (int i = 0; i < 13; i++) dar_tick();
    checks++;
    if (obs !== E_TR) begin failures++; $display("FAIL peaton_rojo_eo: got %h expected %h", obs, E_TR); end
    dar_tick();
    checks++;
    if (obs !== E_NSV) begin failures++; $display("FAIL ped_limpio: got %h expected %h", obs, E_NSV); end
  endtask

  task automatic test_emerg_eo();
    aplicar_reset();
    dar_tick();
    dar_tick();
    checks++;
    if (obs !== E_NSV) begin failures++; $display("FAIL emerg_tick2: got %h expected %h", obs, E_NSV); end
    emerg_eo = 1'b1;
    reloj(1);
    checks++;
    if (obs !== E_NSA) begin failures++; $display("FAIL preempcion_inmediata: got %h expected %h", obs, E_NSA); end
    reloj(3);
    dar_tick();
    dar_tick();
    checks++;
    if (obs !== E_NSA) begin failures++; $display("FAIL preempcion_amarillo: got %h expected %h", obs, E_NSA); end
    dar_tick();
    checks++;
    if (obs !== E_TR) begin failures++; $display("FAIL preempcion_rojo: got %h expected %h", obs, E_TR); end
    dar_tick();
    checks++;
    if (obs !== E_EEO) begin failures++; $display("FAIL emerg_eo_entra: got %h expected %h", obs, E_EEO); end
    for (int i = 0; i < 5; i++) begin
      dar_tick();
      checks++;
      if (obs !== E_EEO) begin failures++; $display("FAIL emerg_sostenida[%0d]: got %h expected %h", i, obs, E_EEO); end
    end
    emerg_eo = 1'b0;
    reloj(1);
    checks++;
    if (obs !== E_EOA) begin failures++; $display("FAIL fin_emerg: got %h expected %h", obs, E_EOA); end
    reloj(3);
    dar_tick();
    dar_tick();
    checks++;
    if (obs !== E_EOA) begin failures++; $display("FAIL fin_emerg_amarillo: got %h expected %h", obs, E_EOA); end
    dar_tick();
    checks++;
    if (obs !== E_TR) begin failures++; $display("FAIL fin_emerg_rojo: got %h expected %h", obs, E_TR); end
    dar_tick();
    checks++;
    if (obs !== E_NSV) begin failures++; $display("FAIL retoma_ns: got %h expected %h", obs, E_NSV); end
  endtask

  task automatic test_emerg_ambas();
    aplicar_reset();
    emerg_ns = 1'b1;
    emerg_eo = 1'b1;
    dar_tick();
    checks++;
    if (obs !== E_ENS) begin failures++; $display("FAIL prioridad_ns: got %h expected %h", obs, E_ENS); end
    emerg_eo = 1'b0;
    for (int i = 0; i < 3; i++) dar_tick();
    checks++;
    if (obs !== E_ENS) begin failures++; $display("FAIL emerg_ns_sostenida: got %h expected %h", obs, E_ENS); end
    emerg_ns = 1'b0;
    reloj(1);
    checks++;
    if (obs !== E_NSA) begin failures++; $display("FAIL fin_emerg_ns: got %h expected %h", obs, E_NSA); end
    reloj(3);
    for (int i = 0; i < 3; i++) dar_tick();
    dar_tick();
    checks++;
    if (obs !== E_EOV) begin failures++; $display("FAIL dir_tras_emerg: got %h expected %h", obs, E_EOV); end
    emerg_eo = 1'b1;
    for (int i = 0; i < 15; i++) dar_tick();
    checks++;
    if (obs !== E_EOV) begin failures++; $display("FAIL verde_extendido: got %h expected %h", obs, E_EOV); end
    emerg_eo = 1'b0;
    dar_tick();
    checks++;
    if (obs !== E_EOA) begin failures++; $display("FAIL fin_extension: got %h expected %h", obs, E_EOA); end
  endtask

  task automatic test_reset_cruce();
    aplicar_reset();
    boton_peaton = 1'b1;
    reloj(1);
    boton_peaton = 1'b0;
    dar_tick();
    checks++;
    if (obs !== E_CRU) begin failures++; $display("FAIL cruce_directo: got %h expected %h", obs, E_CRU); end
    dar_tick();
    dar_tick();
    rst = 1'b0;
    reloj(1);
    checks++;
    if (obs !== E_TR) begin failures++; $display("FAIL reset_en_cruce: got %h expected %h", obs, E_TR); end
    rst = 1'b1;
    reloj(1);
    dar_tick();
    checks++;
    if (obs !== E_NSV) begin failures++; $display("FAIL ped_pend_borrado: got %h expected %h", obs, E_NSV); end
  endtask

  initial begin
    rst = 1'b0; tick = 1'b0; boton_peaton = 1'b0; emerg_ns = 1'b0; emerg_eo = 1'b0;
    test_reset();
    test_ciclo_normal();
    test_peaton();
    test_emerg_eo();
    test_emerg_ambas();
    test_reset_cruce();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
